ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
// Owns the single data-RAM port and shares it between the processor load/store path and a
// result-readout scanner. The scanner streams a WIDTH x HEIGHT result region out after the
// program finishes: pixel(i,j) = RAM[BASE + j + WIDTH*i]. It sits between the processor top
// level and RAM. It replaces the ad-hoc address mux on the done flag with a sequenced arbiter.
// PARAMETERS
// ADDR_W   14   RAM word-address width
// DATA_W   32   RAM data width
// WIDTH    100  columns per scan row (>=1)
// HEIGHT   100  rows per scan (>=1); WIDTH*HEIGHT <= 2**ADDR_W
// BASE     0    first scan word address
// PORTS
// clk         in   1       system clock, all logic on rising edge
// rst_n       in   1       asynchronous, active-low reset
// cpu_req     in   1       processor requests one RAM access this cycle
// cpu_we      in   1       1=write, 0=read (qualified by cpu_req)
// cpu_addr    in   ADDR_W  processor word address
// cpu_wdata   in   DATA_W  processor write data
// cpu_gnt     out  1       access issued to RAM this cycle (combinational)
// cpu_rvalid  out  1       read data valid (1 cycle after granted read)
// cpu_rdata   out  DATA_W  read data
// scan_start  in   1       pulse: begin readout
// scan_busy   out  1       scanner active
// scan_done   out  1       1-cycle pulse: last pixel accepted
// px_valid    out  1       pixel stream valid
// px_data     out  DATA_W  pixel word
// px_ready    in   1       downstream accepts pixel
// ram_en      out  1       RAM access strobe
// ram_we      out  1       RAM write enable
// ram_addr    out  ADDR_W  RAM address
// ram_wdata   out  DATA_W  RAM write data
// ram_rdata   in   DATA_W  RAM read data, 1-cycle latency (addr at n -> data at n+1)
// BEHAVIOUR
// - Reset: all outputs 0; FSM=IDLE; i=j=0; scan address=BASE; pixel FIFO empty; no read in flight.
// - One RAM access per cycle. ram_en/ram_we/ram_addr/ram_wdata are combinational from the winner.
// - CPU path: when granted, cpu_gnt=1 that cycle. For a read, cpu_rvalid=1 and cpu_rdata=ram_rdata
//   on the next cycle. For a write, no rvalid. An ungranted cpu_req must be held by the requester.
// - Scanner FSM: IDLE -scan_start-> SCAN -last addr issued-> DRAIN -last pixel accepted-> IDLE.
//   scan_done pulses on that last handshake. scan_busy=1 in SCAN and DRAIN.
//   scan_start while busy is ignored.
// - Scanner wants the port in SCAN only while (FIFO occupancy + reads in flight) < 2.
//   The FIFO is 2 entries; a full FIFO stalls issue and never overflows.
// - Address: running register, +1 per issued read. j wraps at WIDTH-1 -> 0 and i increments.
//   The last address is BASE+WIDTH*HEIGHT-1. No multiplier. Sum is modulo 2**ADDR_W.
// - px_data is FIFO head, stable while px_valid & !px_ready. A pixel is transferred on px_valid & px_ready.
//   A same-cycle push and pop keeps occupancy unchanged.
// - A pixel reflects RAM contents at its issue cycle. CPU writes during a scan are allowed
//   and are not reordered.
// - WIDTH=1 or HEIGHT=1 are legal. A 1x1 scan goes SCAN->DRAIN after 1 issue.
// - rst_n asserted mid-scan: immediate return to reset state, FIFO flushed, in-flight read discarded,
//   no scan_done.
// CONFIGURATION
// ARB_ROUND_ROBIN_EN defined: on conflict (cpu_req and scanner wants the port), the winner alternates.
//   A last-winner flag resets to "scanner", so the CPU wins the first conflict.
//   Non-conflicting cycles do not update the flag.
// ARB_ROUND_ROBIN_EN undefined: fixed priority, CPU always wins; the scanner uses idle cycles only.
// TESTING
// 1 CPU write addr 5 data 0xA5A5A5A5, then read addr 5 -> gnt both cycles; rvalid next cycle, rdata=0xA5A5A5A5.
// 2 WIDTH=3,HEIGHT=2,BASE=10, RAM[k]=k, px_ready=1 -> px_data 10..15 in order, scan_done after 15, busy drops.
// 3 Same scan, px_ready=0 for 10 cycles -> exactly 2 reads issued, px_data holds 10, then resumes with no loss.
// 4 cpu_req held high during scan: fixed -> scanner issues 0 reads; RR -> grants alternate CPU,scan,CPU,...
// 5 rst_n low after 3 pixels -> outputs 0 next edge-free instant; new scan_start restarts at BASE.
// 6 scan_start pulsed while busy -> ignored, single scan_done, pixel count = WIDTH*HEIGHT.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Shares the single data-RAM port between the CPU load/store path and a result-region
// readout scanner. Define ARB_ROUND_ROBIN_EN for alternating priority; default is CPU-first.
module ram_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              scan_start,
  output logic              scan_busy,
  output logic              scan_done,
  output logic              px_valid,
  output logic [DATA_W-1:0] px_data,
  input  logic              px_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} stateT;

  stateT             state;
  logic [ADDR_W-1:0] scanAddr;
  logic [COL_W-1:0]  colIdx;
  logic [ROW_W-1:0]  rowIdx;
  logic [DATA_W-1:0] fifoMem [2];
  logic              wrPtr;
  logic              rdPtr;
  logic [1:0]        fifoCount;
  logic              scanInFlight;
  logic              cpuReadPending;
  logic              scanWant;
  logic              cpuWin;
  logic              scanWin;
  logic              push;
  logic              pop;
  logic              lastIssue;
`ifdef ARB_ROUND_ROBIN_EN
  logic              lastWinScan;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    scanWant = 1'b0;
    cpuWin   = 1'b0;
    // Occupancy plus in-flight reads bounds issue, so the 2-entry FIFO can never overflow.
    scanWant = (state == SCAN) && ((fifoCount + {1'b0, scanInFlight}) < 2'd2);
`ifdef ARB_ROUND_ROBIN_EN
    cpuWin   = cpu_req && (!scanWant || lastWinScan);
`else
    cpuWin   = cpu_req;
`endif
  end

  assign scanWin   = scanWant && !cpuWin;
  assign lastIssue = scanWin && (rowIdx == LAST_ROW) && (colIdx == LAST_COL);
  assign push      = scanInFlight;
  assign pop       = px_valid && px_ready;

  assign cpu_gnt    = cpuWin;
  assign ram_en     = cpuWin || scanWin;
  assign ram_we     = cpuWin && cpu_we;
  assign ram_addr   = cpuWin ? cpu_addr : (scanWin ? scanAddr : '0);
  assign ram_wdata  = cpuWin ? cpu_wdata : '0;
  assign cpu_rvalid = cpuReadPending;
  assign cpu_rdata  = cpuReadPending ? ram_rdata : '0;
  assign px_valid   = (fifoCount != 2'd0);
  assign px_data    = px_valid ? fifoMem[rdPtr] : '0;
  assign scan_busy  = (state != IDLE);
  assign scan_done  = (state == DRAIN) && pop && (fifoCount == 2'd1) && !scanInFlight;

  // NOTE: the FIFO storage is not reset; px_data is masked by px_valid, so stale words never escape.
  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= ram_rdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so update order never matters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      scanAddr       <= ADDR_W'(BASE);
      colIdx         <= '0;
      rowIdx         <= '0;
      wrPtr          <= 1'b0;
      rdPtr          <= 1'b0;
      fifoCount      <= 2'd0;
      scanInFlight   <= 1'b0;
      cpuReadPending <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      lastWinScan    <= 1'b1;
`endif
    end else begin
      cpuReadPending <= cpuWin && !cpu_we;
      scanInFlight   <= scanWin;
      if (push) wrPtr <= ~wrPtr;
      if (pop)  rdPtr <= ~rdPtr;
      if (push && !pop)      fifoCount <= fifoCount + 2'd1;
      else if (pop && !push) fifoCount <= fifoCount - 2'd1;
`ifdef ARB_ROUND_ROBIN_EN
      if (cpu_req && scanWant) lastWinScan <= scanWin;
`endif
      case (state)
        IDLE: begin
          if (scan_start) begin
            state    <= SCAN;
            scanAddr <= ADDR_W'(BASE);
            colIdx   <= '0;
            rowIdx   <= '0;
          end
        end
        SCAN: begin
          if (scanWin) begin
            // Running address replaces BASE + j + WIDTH*i, so no multiplier is needed.
            scanAddr <= scanAddr + ADDR_W'(1);
            if (colIdx == LAST_COL) begin
              colIdx <= '0;
              rowIdx <= rowIdx + ROW_W'(1);
            end else begin
              colIdx <= colIdx + COL_W'(1);
            end
            if (lastIssue) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (scan_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: CPU vector table plus hand-written scan sequences
// on a 3x2 region at BASE 10, with a small synchronous RAM model preloaded with RAM[k]=k.
module tb_ram_port_arbiter;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int WIDTH  = 3;
  localparam int HEIGHT = 2;
  localparam int BASE   = 10;
  localparam int NPX    = WIDTH * HEIGHT;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              scan_start, scan_busy, scan_done;
  logic              px_valid, px_ready;
  logic [DATA_W-1:0] px_data;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  int compared = 0;
  int mismatched = 0;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .scan_start(scan_start), .scan_busy(scan_busy), .scan_done(scan_done),
    .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: 1-cycle read latency, contents restored to RAM[k]=k on reset.
  logic [DATA_W-1:0] ramMem [64];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 64; k++) ramMem[k] <= DATA_W'(k);
      ram_rdata <= '0;
    end else if (ram_en) begin
      if (ram_we) ramMem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ramMem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string name);
    check({name, " ctl"}, 64'({cpu_gnt, cpu_rvalid, scan_busy, scan_done, px_valid, ram_en, ram_we}), 64'd0);
    check({name, " data"}, 64'(cpu_rdata | px_data | ram_wdata), 64'd0);
    check({name, " addr"}, 64'(ram_addr), 64'd0);
  endtask

  typedef struct {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              expGnt;
    logic              expEn;
    logic              expWe;
    logic [ADDR_W-1:0] expAddr;
    logic              expRvalid;
    logic [DATA_W-1:0] expRdata;
  } cpuVecT;

  cpuVecT vecs [8];

  // Runs one full scan. stallCyc: px_ready low for that many cycles; cpuHold: cpu_req high
  // for that many cycles; restartAt: cycle at which scan_start is re-pulsed while busy.
  task automatic runScan(input string name, input int stallCyc, input int cpuHold, input int restartAt);
    int px = 0;
    int dones = 0;
    int scanIssues = 0;
    int stallIssues = 0;
    bit finished = 1'b0;
    @(posedge clk); #1;
    scan_start = 1'b1;
    px_ready   = (stallCyc == 0);
    cpu_req    = (cpuHold > 0);
    cpu_we     = 1'b0;
    cpu_addr   = '0;
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      @(negedge clk);
      if (ram_en && !cpu_gnt) begin
        scanIssues++;
        if (cyc < stallCyc) stallIssues++;
      end
      if (cyc < cpuHold) begin
`ifdef ARB_ROUND_ROBIN_EN
        check($sformatf("%s gnt c%0d", name, cyc), 64'(cpu_gnt), 64'((cyc == 0) || (cyc % 2 == 1)));
        if (cyc == cpuHold - 1) check({name, " issues in hold"}, 64'(scanIssues), 64'((cpuHold - 1) / 2));
`else
        check($sformatf("%s gnt c%0d", name, cyc), 64'(cpu_gnt), 64'd1);
        if (cyc == cpuHold - 1) check({name, " issues in hold"}, 64'(scanIssues), 64'd0);
`endif
      end
      if (stallCyc > 0 && cyc == stallCyc - 1) begin
        check({name, " stall issues"}, 64'(stallIssues), 64'd2);
        check({name, " stall valid"}, 64'(px_valid), 64'd1);
        check({name, " stall head"}, 64'(px_data), 64'(BASE));
      end
      if (scan_done) begin
        dones++;
        check({name, " done on last px"}, 64'({px_valid && px_ready, px}), 64'({1'b1, 32'(NPX - 1)}));
        finished = 1'b1;
      end
      if (px_valid && px_ready) begin
        check($sformatf("%s px%0d", name, px), 64'(px_data), 64'(BASE + px));
        px++;
      end
      @(posedge clk); #1;
      scan_start = (cyc + 1 == restartAt);
      px_ready   = (cyc + 1 >= stallCyc);
      cpu_req    = (cyc + 1 < cpuHold);
    end
    scan_start = 1'b0;
    cpu_req    = 1'b0;
    check({name, " px count"}, 64'(px), 64'(NPX));
    check({name, " done count"}, 64'(dones), 64'd1);
    check({name, " busy after"}, 64'(scan_busy), 64'd0);
    check({name, " valid after"}, 64'(px_valid), 64'd0);
  endtask

  initial begin
    int px;
    rst_n      = 1'b0;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    scan_start = 1'b0;
    px_ready   = 1'b0;

    //          req  we  addr wdata          gnt en  we  addr rv  rdata
    vecs[0] = '{1'b1, 1'b1, 6'd5, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1, 6'd5, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 6'd5, 32'h0,        1'b1, 1'b1, 1'b0, 6'd5, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 6'd9, 32'h0,        1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 32'hA5A5A5A5};
    vecs[3] = '{1'b1, 1'b1, 6'd7, 32'h12345678, 1'b1, 1'b1, 1'b1, 6'd7, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 6'd7, 32'h0,        1'b1, 1'b1, 1'b0, 6'd7, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 6'd5, 32'h0,        1'b1, 1'b1, 1'b0, 6'd5, 1'b1, 32'h12345678};
    vecs[6] = '{1'b0, 1'b1, 6'd3, 32'hFFFF0000, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 32'hA5A5A5A5};
    vecs[7] = '{1'b0, 1'b0, 6'd0, 32'h0,        1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0};

    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      @(posedge clk); #1;
      cpu_req   = vecs[v].req;
      cpu_we    = vecs[v].we;
      cpu_addr  = vecs[v].addr;
      cpu_wdata = vecs[v].wdata;
      @(negedge clk);
      check($sformatf("vec%0d gnt", v), 64'(cpu_gnt), 64'(vecs[v].expGnt));
      check($sformatf("vec%0d ram ctl", v), 64'({ram_en, ram_we}), 64'({vecs[v].expEn, vecs[v].expWe}));
      check($sformatf("vec%0d ram addr", v), 64'(ram_addr), 64'(vecs[v].expAddr));
      if (vecs[v].expWe) check($sformatf("vec%0d ram wdata", v), 64'(ram_wdata), 64'(vecs[v].wdata));
      check($sformatf("vec%0d rvalid", v), 64'(cpu_rvalid), 64'(vecs[v].expRvalid));
      check($sformatf("vec%0d rdata", v), 64'(cpu_rdata), 64'(vecs[v].expRdata));
    end
    cpu_req = 1'b0;
    cpu_we  = 1'b0;

    runScan("scan", 0, 0, -1);
    runScan("stall", 10, 0, -1);
    runScan("cpuhold", 0, 13, -1);
    runScan("restart", 0, 0, 4);

    // Abort mid-scan after three pixels, then confirm a clean restart from BASE.
    px = 0;
    @(posedge clk); #1;
    scan_start = 1'b1;
    px_ready   = 1'b1;
    for (int cyc = 0; cyc < 50 && px < 3; cyc++) begin
      @(negedge clk);
      check($sformatf("abort no done c%0d", cyc), 64'(scan_done), 64'd0);
      if (px_valid && px_ready) px++;
      @(posedge clk); #1;
      scan_start = 1'b0;
    end
    check("abort px before reset", 64'(px), 64'd3);
    rst_n = 1'b0;
    #1;
    checkAllZero("abort");
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("abort held");
    rst_n = 1'b1;
    runScan("after abort", 0, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
